divu_seq_shift_sub: RTL

//  Sequential unsigned restoring (shift/subtract) divider. Inverse companion of the

---
 rtl/divu_seq_shift_sub.sv | 121 ++++++++++++
 1 files changed

// File: rtl/divu_seq_shift_sub.sv
// Sequential unsigned restoring divider: 2*BITS-bit dividend by BITS-bit divisor,
// one quotient bit per cycle, start/done handshake with a divide-by-zero shortcut.
module divu_seq_shift_sub #(
  parameter int BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2*BITS-1:0] dividend,
  input  logic [BITS-1:0]   divisor,
  output logic              busy,
  output logic              done,
  output logic [2*BITS-1:0] quotient,
  output logic [BITS-1:0]   remainder,
  output logic              div_by_zero
);

  localparam int QW = 2 * BITS;
  localparam int CW = $clog2(QW + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [QW-1:0]     q_q, q_d;
  logic [BITS-1:0]   d_q, d_d;
  logic [BITS:0]     r_q, r_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;
  logic [QW-1:0]     quot_q, quot_d;
  logic [BITS-1:0]   rem_q, rem_d;

  // One restoring step; trial value carries a spare MSB so the compare never wraps.
  logic [BITS+1:0]   trial;
  logic [BITS+1:0]   d_ext;
  logic              fits;
  logic [BITS:0]     r_next;
  logic [QW-1:0]     q_next;

  always_comb begin
    trial  = {r_q, q_q[QW-1]};
    d_ext  = {2'b00, d_q};
    fits   = (trial >= d_ext);
    r_next = (BITS+1)'(fits ? (trial - d_ext) : trial);
    q_next = {q_q[QW-2:0], fits};
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          q_d   = dividend;
          d_d   = divisor;
          r_d   = '0;
          cnt_d = CW'(QW);
          if (divisor == '0) begin
            done_d = 1'b1;
            dbz_d  = 1'b1;
            quot_d = '1;
            rem_d  = dividend[BITS-1:0];
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          dbz_d   = 1'b0;
          quot_d  = q_next;
          rem_d   = r_next[BITS-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;

endmodule
